// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - shared types, opcodes and immediate limits for the RV instruction encoder
package rv_enc_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  // Signed limits of the encodable immediates (B/J are byte offsets, even only)
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -(1 << 20);
  localparam int IMMJ_MAX  = (1 << 20) - 2;

  // Fields captured by the check stage; src kept raw so unused codes survive
  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  src;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        is_r;
    logic        err;
  } s1_fields_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - opcode to immediate-format decode
module instr_decoder
  import rv_enc_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [2:0] o_imm_src,
  output logic       o_is_r
);

  // Map the major opcode to its immediate format; register-register ops flagged separately
  always_comb begin
    o_imm_src = IMM_I;
    o_is_r    = 1'b0;
    case (i_op)
      LOAD, OP_IMM, JALR, OP_IMM_32: o_imm_src = IMM_I;
      STORE:                         o_imm_src = IMM_S;
      BRANCH:                        o_imm_src = IMM_B;
      JAL:                           o_imm_src = IMM_J;
      AUIPC, LUI:                    o_imm_src = IMM_U;
      OP, OP_32:                     o_is_r    = 1'b1;
      default:                       o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage valid/ready RV instruction word packer with field checks
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int OP_WIDTH  = 7,
  parameter int OUT_WIDTH = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [OP_WIDTH-1:0]  i_op,
  input  logic [OUT_WIDTH-1:0] i_imm_src,
  input  logic [4:0]           i_rd,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [2:0]           i_funct3,
  input  logic [6:0]           i_funct7,
  input  logic [31:0]          i_imm,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_instr,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  logic [2:0]         dec_src;
  logic               dec_is_r;
  logic signed [31:0] imm_s;
  logic               range_err;
  logic               src_err;

  logic               s1_valid_q, s1_valid_d;
  s1_fields_t         s1_q, s1_d;
  logic               s2_valid_q, s2_valid_d;
  logic [31:0]        instr_q, instr_d;
  logic               err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic               s1_ready, s1_load;
  logic               s2_ready, s2_load;
  logic [31:0]        packed_word;

  instr_decoder u_dec (
    .i_op      (i_op),
    .o_imm_src (dec_src),
    .o_is_r    (dec_is_r)
  );

  // Immediate range/alignment and format/opcode consistency checks on the incoming fields
  always_comb begin
    imm_s     = $signed(i_imm);
    range_err = 1'b0;
    case (i_imm_src)
      IMM_I, IMM_S: range_err = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      IMM_B:        range_err = (imm_s < IMMB_MIN) || (imm_s > IMMB_MAX) || i_imm[0];
      IMM_J:        range_err = (imm_s < IMMJ_MIN) || (imm_s > IMMJ_MAX) || i_imm[0];
      IMM_U:        range_err = |i_imm[11:0];
      default:      range_err = 1'b1;
    endcase
    src_err = !dec_is_r && (i_imm_src != dec_src);
  end

  // Handshake: each stage accepts when empty or when the stage after it drains
  always_comb begin
    s2_ready   = !s2_valid_q || i_ready;
    s2_load    = s1_valid_q && s2_ready;
    s1_ready   = !s1_valid_q || s2_ready;
    s1_load    = i_valid && s1_ready;
    s1_valid_d = s1_load || (s1_valid_q && !s2_ready);
    s2_valid_d = s2_load || (s2_valid_q && !i_ready);
  end

  // Check stage: capture fields and the computed error flag on accept, else hold
  always_comb begin
    s1_d = s1_q;
    if (s1_load) begin
      s1_d.op     = i_op;
      s1_d.src    = i_imm_src;
      s1_d.rd     = i_rd;
      s1_d.rs1    = i_rs1;
      s1_d.rs2    = i_rs2;
      s1_d.funct3 = i_funct3;
      s1_d.funct7 = i_funct7;
      s1_d.imm    = i_imm;
      s1_d.is_r   = dec_is_r;
      s1_d.err    = range_err || src_err;
    end
  end

  // Pack stage: register-register ops by opcode, everything else by immediate format
  always_comb begin
    packed_word = 32'h0;
    if (s1_q.is_r) begin
      packed_word = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.op};
    end else begin
      case (s1_q.src)
        IMM_S: packed_word = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                              s1_q.imm[4:0], s1_q.op};
        IMM_B: packed_word = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                              s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], s1_q.op};
        IMM_U: packed_word = {s1_q.imm[31:12], s1_q.rd, s1_q.op};
        IMM_J: packed_word = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                              s1_q.imm[19:12], s1_q.rd, s1_q.op};
        default: packed_word = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.op};
      endcase
    end
  end

  // Output register loads from the pack stage and holds while downstream stalls
  always_comb begin
    instr_d = instr_q;
    err_d   = err_q;
    if (s2_load) begin
      instr_d = packed_word;
      err_d   = s1_q.err;
    end
  end

  // Saturating count of erroneous words that actually leave the encoder
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && i_ready && err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset discarding any in-flight words
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      instr_q    <= 32'h0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      instr_q    <= instr_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_ready   = s1_ready;
  assign o_valid   = s2_valid_q;
  assign o_instr   = instr_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

endmodule
